sb_uart: RTL and testbench

Memory-mapped 8N1 UART responder for the system bridge, placed beside the two timer peripherals and exposing the same word-addressed register-port style: `Addr`, `WE`, `Din`, `Dout` and `IRQ`. It serialises bytes written by the CPU onto `txd` and deserialises `rxd` into a one-byte receive holding register. It raises a level interrupt that is routed into one of the CPU's spare `irq` bits.

---
 rtl/sb_uart_pkg.sv | 25 ++
 rtl/sb_uart_if.sv | 12 +
 rtl/sb_uart_rx.sv | 76 +++++++
 rtl/sb_uart.sv | 140 ++++++++++++++
 tb/tb_sb_uart.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sb_uart_pkg.sv
// Shared constants and state types for the sb_uart register-port UART.
package sb_uart_pkg;
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  localparam int ST_RXV = 0;
  localparam int ST_TXI = 1;
  localparam int ST_OVR = 2;
  localparam int ST_FER = 3;

  localparam int CT_RXIE = 0;
  localparam int CT_TXIE = 1;
  localparam int CT_CLR  = 2;

  localparam logic [15:0] MIN_DIV = 16'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction
endpackage

// File: rtl/sb_uart_if.sv
// Word-addressed register port shared with the bridge timer peripherals.
interface sb_uart_if;
  logic [29:0] Addr;
  logic        WE;
  logic        RE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  modport master (output Addr, WE, RE, Din, input Dout, IRQ);
  modport slave  (input Addr, WE, RE, Din, output Dout, IRQ);
endinterface

// File: rtl/sb_uart_rx.sv
// Receive datapath: 2-flop synchroniser, mid-bit sampler and 8N1 frame FSM.
module sb_uart_rx
  import sb_uart_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        rxd,
  input  logic [15:0] div,
  output logic [7:0]  rx_data,
  output logic        byte_stb,
  output logic        ferr_stb
);
  rx_state_e   state, nstate;
  logic        s1, s2, prev;
  logic [15:0] cnt, rdiv;
  logic [2:0]  bitn;
  logic [7:0]  shreg;
  logic        tick;

  always_comb begin
    nstate = state;
    tick   = 1'b0;
    case (state)
      RX_IDLE:  if (prev && !s2) nstate = RX_START;
      // a start bit that has gone high again by mid-bit is a glitch
      RX_START: if (cnt == (rdiv >> 1) - 16'd1) begin
                  tick   = 1'b1;
                  nstate = s2 ? RX_IDLE : RX_DATA;
                end
      RX_DATA:  if (cnt == rdiv - 16'd1) begin
                  tick = 1'b1;
                  if (bitn == 3'd7) nstate = RX_STOP;
                end
      RX_STOP:  if (cnt == rdiv - 16'd1) begin
                  tick   = 1'b1;
                  nstate = RX_IDLE;
                end
      default:  nstate = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RX_IDLE;
      s1    <= 1'b1;
      s2    <= 1'b1;
      prev  <= 1'b1;
      cnt   <= '0;
      rdiv  <= MIN_DIV;
      bitn  <= '0;
      shreg <= '0;
    end else begin
      s1    <= rxd;
      s2    <= s1;
      prev  <= s2;
      state <= nstate;
      if (state == RX_IDLE) begin
        cnt  <= '0;
        bitn <= '0;
        rdiv <= div;
      end else if (tick) begin
        cnt <= '0;
        if (state == RX_DATA) begin
          shreg <= {s2, shreg[7:1]};
          bitn  <= bitn + 3'd1;
        end
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  assign rx_data  = shreg;
  assign byte_stb = (state == RX_STOP) && tick;
  assign ferr_stb = byte_stb && !s2;
endmodule

// File: rtl/sb_uart.sv
// 8N1 UART responder: register file, TX serialiser and level IRQ.
module sb_uart
  import sb_uart_pkg::*;
#(
  parameter int DEFAULT_DIV = 16
) (
  input  logic    clk,
  input  logic    reset,
  sb_uart_if.slave bus,
  input  logic    rxd,
  output logic    txd
);
  logic [1:0]  sel, ctrl;
  logic        wr_data, wr_ctrl, wr_div, rd_data, clr;
  logic [15:0] divisor, tx_div, tx_cnt;
  logic [7:0]  tx_sh, rx_byte, rx_data;
  logic [2:0]  tx_bit;
  logic        rx_valid, tx_idle, overrun, frame_err, irq;
  logic        byte_stb, ferr_stb, tx_start, tx_tick, txd_n;
  logic [3:0]  status;
  tx_state_e   tx_state, tx_next;
  logic        unused_ok;

  assign sel     = bus.Addr[1:0];
  assign wr_data = bus.WE && sel == REG_DATA;
  assign wr_ctrl = bus.WE && sel == REG_CTRL;
  assign wr_div  = bus.WE && sel == REG_DIV;
  assign rd_data = bus.RE && sel == REG_DATA;
  assign clr     = wr_ctrl && bus.Din[CT_CLR];
  assign unused_ok = ^{bus.Addr[29:2], bus.Din[31:16]};

  sb_uart_rx u_rx (
    .clk(clk), .reset(reset), .rxd(rxd), .div(divisor),
    .rx_data(rx_data), .byte_stb(byte_stb), .ferr_stb(ferr_stb)
  );

  assign tx_start = wr_data && tx_state == TX_IDLE;
  assign tx_tick  = tx_cnt == tx_div - 16'd1;

  always_comb begin
    tx_next = tx_state;
    txd_n   = 1'b1;
    case (tx_state)
      TX_IDLE:  if (tx_start) tx_next = TX_START;
      TX_START: begin
                  txd_n = 1'b0;
                  if (tx_tick) tx_next = TX_DATA;
                end
      TX_DATA:  begin
                  txd_n = tx_sh[0];
                  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
                end
      TX_STOP:  if (tx_tick) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // txd is registered from the current state, so the line trails the FSM by one clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      txd      <= 1'b1;
      tx_idle  <= 1'b1;
      tx_sh    <= '0;
      tx_div   <= 16'(DEFAULT_DIV);
      tx_cnt   <= '0;
      tx_bit   <= '0;
    end else begin
      tx_state <= tx_next;
      txd      <= txd_n;
      tx_idle  <= (tx_state == TX_IDLE) && !tx_start;
      if (tx_start) begin
        tx_sh  <= bus.Din[7:0];
        tx_div <= divisor;
        tx_cnt <= '0;
        tx_bit <= '0;
      end else if (tx_state != TX_IDLE) begin
        if (tx_tick) begin
          tx_cnt <= '0;
          if (tx_state == TX_DATA) begin
            tx_sh  <= tx_sh >> 1;
            tx_bit <= tx_bit + 3'd1;
          end
        end else begin
          tx_cnt <= tx_cnt + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_valid  <= 1'b0;
      rx_byte   <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      ctrl      <= '0;
      divisor   <= 16'(DEFAULT_DIV);
      irq       <= 1'b0;
    end else begin
      // a read in the same cycle as a delivery frees the slot, so no overrun
      if (byte_stb) begin
        if (!rx_valid || rd_data) begin
          rx_byte  <= rx_data;
          rx_valid <= 1'b1;
        end
      end else if (rd_data) begin
        rx_valid <= 1'b0;
      end
      if (byte_stb && rx_valid && !rd_data) overrun <= 1'b1;
      else if (clr)                         overrun <= 1'b0;
      if (ferr_stb)  frame_err <= 1'b1;
      else if (clr)  frame_err <= 1'b0;
      if (wr_ctrl) ctrl    <= bus.Din[1:0];
      if (wr_div)  divisor <= clamp_div(bus.Din[15:0]);
      irq <= (rx_valid && ctrl[CT_RXIE]) || (tx_idle && ctrl[CT_TXIE]);
    end
  end

  always_comb begin
    status         = '0;
    status[ST_RXV] = rx_valid;
    status[ST_TXI] = tx_idle;
    status[ST_OVR] = overrun;
    status[ST_FER] = frame_err;
  end

  always_comb begin
    bus.Dout = '0;
    case (sel)
      REG_DATA:   bus.Dout = {24'b0, rx_byte};
      REG_STATUS: bus.Dout = {28'b0, status};
      REG_CTRL:   bus.Dout = {30'b0, ctrl};
      REG_DIV:    bus.Dout = {16'b0, divisor};
      default:    bus.Dout = '0;
    endcase
  end

  assign bus.IRQ = irq;
endmodule

// File: tb/tb_sb_uart.sv
// Self-checking bench for sb_uart: register vector table plus TX/RX frame sequences.
module tb_sb_uart;
  localparam int DIV = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rxd = 1'b1;
  logic txd;
  int   total = 0;
  int   bad = 0;
  int   tb_div = DIV;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  sb_uart_if bus();

  sb_uart #(.DEFAULT_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .bus(bus), .rxd(rxd), .txd(txd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [29:0] a;
    logic [31:0] d;
    logic [31:0] e;
  } vec_t;
  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [29:0] a, input logic [31:0] d);
    bus.Addr = a; bus.Din = d; bus.WE = 1'b1;
    step();
    bus.WE = 1'b0;
  endtask

  task automatic rd(input logic [29:0] a, output logic [31:0] d);
    bus.Addr = a;
    #1;
    d = bus.Dout;
  endtask

  task automatic rd_clr();
    bus.Addr = 30'd0; bus.RE = 1'b1;
    step();
    bus.RE = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopb);
    rxd = 1'b0;
    step(tb_div);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      step(tb_div);
    end
    rxd = stopb;
    step(tb_div);
    rxd = 1'b1;
  endtask

  task automatic wait_rxv(input string name);
    int n = 0;
    bus.Addr = 30'd1;
    #1;
    while (!bus.Dout[0] && n < 400) begin
      step();
      n++;
    end
    chk(name, {31'b0, bus.Dout[0]}, 32'd1);
  endtask

  // TX monitor: decode each frame at mid-bit, compare against the scoreboard
  initial begin
    forever begin
      @(negedge txd);
      begin
        logic [9:0] fr;
        logic [7:0] e;
        int d;
        d = tb_div;
        repeat (d / 2) @(posedge clk);
        #1 fr[0] = txd;
        for (int i = 1; i < 10; i++) begin
          repeat (d) @(posedge clk);
          #1 fr[i] = txd;
        end
        if (tx_exp.size() > 0) begin
          e = tx_exp.pop_front();
          chk("tx_frame", {22'b0, fr}, {22'b0, 1'b1, e, 1'b0});
        end
      end
    end
  end

  initial begin
    logic [31:0] d;
    logic [9:0]  fr;
    vt[0]  = '{1'b0, 30'd1,     32'd0,          32'd2};
    vt[1]  = '{1'b0, 30'd3,     32'd0,          32'd16};
    vt[2]  = '{1'b0, 30'd2,     32'd0,          32'd0};
    vt[3]  = '{1'b0, 30'd0,     32'd0,          32'd0};
    vt[4]  = '{1'b1, 30'd3,     32'd2,          32'd4};
    vt[5]  = '{1'b1, 30'd3,     32'd3,          32'd4};
    vt[6]  = '{1'b1, 30'd3,     32'h0001_0000,  32'd4};
    vt[7]  = '{1'b1, 30'd3,     32'd5,          32'd5};
    vt[8]  = '{1'b1, 30'd3,     32'hABCD_0100,  32'h100};
    vt[9]  = '{1'b1, 30'h403,   32'd16,         32'd16};
    vt[10] = '{1'b1, 30'd2,     32'd3,          32'd3};
    vt[11] = '{1'b1, 30'd2,     32'd0,          32'd0};
    vt[12] = '{1'b1, 30'h401,   32'hFFFF,       32'd2};

    bus.Addr = '0; bus.WE = 1'b0; bus.RE = 1'b0; bus.Din = '0;
    #2 reset = 1'b0;
    step(3);
    reset = 1'b1;
    step();
    chk("rst_txd", {31'b0, txd}, 32'd1);
    chk("rst_irq", {31'b0, bus.IRQ}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      if (vt[i].w) wr(vt[i].a, vt[i].d);
      rd(vt[i].a, d);
      chk($sformatf("vec%0d", i), d, vt[i].e);
    end

    // tx_ie alone: IRQ follows tx_idle one clock after CTRL is written
    wr(30'd2, 32'd2);
    chk("irq_txie_lag", {31'b0, bus.IRQ}, 32'd0);
    step();
    chk("irq_txie", {31'b0, bus.IRQ}, 32'd1);
    wr(30'd2, 32'd0);
    step();

    // TX 0xA5 with a second write mid-frame that must be ignored
    fr = {1'b1, 8'hA5, 1'b0};
    tx_exp.push_back(8'hA5);
    bus.Addr = 30'd0; bus.Din = 32'hA5; bus.WE = 1'b1;
    step();
    bus.WE = 1'b0; bus.Addr = 30'd1;
    chk("txd_pre", {31'b0, txd}, 32'd1);
    for (int k = 1; k <= 165; k++) begin
      step();
      if (k == 50) begin bus.Addr = 30'd0; bus.Din = 32'hFF; bus.WE = 1'b1; end
      if (k == 51) begin bus.WE = 1'b0; bus.Addr = 30'd1; end
      if (k == 1) chk("txd_fall", {31'b0, txd}, 32'd0);
      if (k >= 9 && k <= 153 && (k - 9) % 16 == 0)
        chk($sformatf("txd_bit%0d", (k - 9) / 16), {31'b0, txd}, {31'b0, fr[(k - 9) / 16]});
      if (k == 160) chk("tx_busy_end", {31'b0, bus.Dout[1]}, 32'd0);
      if (k == 161) chk("tx_idle_back", {31'b0, bus.Dout[1]}, 32'd1);
    end
    chk("tx_q_empty", tx_exp.size(), 32'd0);

    // RX 0x3C with rx_ie
    wr(30'd2, 32'd1);
    rx_exp.push_back(8'h3C);
    send_rx(8'h3C, 1'b1);
    wait_rxv("rx1_valid");
    chk("rx1_irq", {31'b0, bus.IRQ}, 32'd1);
    rd(30'd0, d);
    chk("rx1_data", d, {24'b0, rx_exp.pop_front()});
    rd_clr();
    rd(30'd1, d);
    chk("rx1_cleared", {31'b0, d[0]}, 32'd0);
    chk("rx1_irq_lag", {31'b0, bus.IRQ}, 32'd1);
    step();
    chk("rx1_irq_fall", {31'b0, bus.IRQ}, 32'd0);

    // overrun: second byte dropped, first kept
    rx_exp.push_back(8'h11);
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    wait_rxv("ovr_valid");
    step(4);
    rd(30'd1, d);
    chk("ovr_set", {31'b0, d[2]}, 32'd1);
    rd(30'd0, d);
    chk("ovr_data", d, {24'b0, rx_exp.pop_front()});
    wr(30'd2, 32'd5);
    rd(30'd1, d);
    chk("ovr_clr", {31'b0, d[2]}, 32'd0);
    rd_clr();

    // frame error: byte still delivered
    rx_exp.push_back(8'h5A);
    send_rx(8'h5A, 1'b0);
    wait_rxv("fe_valid");
    rd(30'd1, d);
    chk("fe_set", {31'b0, d[3]}, 32'd1);
    rd(30'd0, d);
    chk("fe_data", d, {24'b0, rx_exp.pop_front()});
    rd_clr();
    wr(30'd2, 32'd5);
    rd(30'd1, d);
    chk("fe_clr_status", d, 32'd2);

    // 3-clock glitch: no delivery, then a clean frame still decodes
    rxd = 1'b0;
    step(3);
    rxd = 1'b1;
    step(200);
    rd(30'd1, d);
    chk("glitch_none", d, 32'd2);
    rx_exp.push_back(8'h96);
    send_rx(8'h96, 1'b1);
    wait_rxv("post_glitch_valid");
    rd(30'd0, d);
    chk("post_glitch_data", d, {24'b0, rx_exp.pop_front()});
    rd(30'd1, d);
    chk("post_glitch_status", d, 32'd3);
    rd_clr();
    chk("rx_q_empty", rx_exp.size(), 32'd0);

    // clamped divisor, then reset in the middle of a TX frame
    wr(30'd3, 32'd2);
    rd(30'd3, d);
    chk("div_clamp", d, 32'd4);
    tb_div = 4;
    wr(30'd0, 32'h00);
    step(10);
    chk("tx_mid_low", {31'b0, txd}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_mid_txd", {31'b0, txd}, 32'd1);
    rd(30'd1, d);
    chk("rst_mid_status", d, 32'd2);
    chk("rst_mid_irq", {31'b0, bus.IRQ}, 32'd0);
    step();
    reset = 1'b1;
    step(2);
    rd(30'd3, d);
    chk("rst_div", d, 32'd16);
    chk("rst_txd_hold", {31'b0, txd}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
